// File: rtl/node_call_master.sv
// node_call_master: drives one ST/RD/RES node call per accepted job and
// returns the child's RES on a valid/ready response port.
// Optional watchdog: define NODE_CALL_TIMEOUT_EN to abort runs that exceed
// TIMEOUT cycles from ST assertion (error response, RSP_DATA=0, RSP_ERR=1).
module node_call_master #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [WIDTH-1:0] REQ_A,
    input  logic [WIDTH-1:0] REQ_B,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [WIDTH-1:0] RSP_DATA,
    output logic             RSP_ERR,
    output logic             ST,
    input  logic             RD,
    input  logic [WIDTH-1:0] RES,
    output logic [WIDTH-1:0] ARG0,
    output logic [WIDTH-1:0] ARG1,
    output logic             BUSY
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, RESP} state_t;

    // The watchdog counter is 16 bits, so the limit must fit in it.
    generate
        if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
            $error("node_call_master: TIMEOUT must be in 1..65535");
        end
    endgenerate

    state_t           state_q, state_d;
    logic             st_q, st_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [WIDTH-1:0] arg0_q, arg0_d;
    logic [WIDTH-1:0] arg1_q, arg1_d;
`ifdef NODE_CALL_TIMEOUT_EN
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);
    logic             rsp_err_q, rsp_err_d;
    logic [15:0]      wd_cnt_q, wd_cnt_d, wd_inc;
`endif

    // Next-state and next-output logic for the call sequence.
    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        arg0_d      = arg0_q;
        arg1_d      = arg1_q;
`ifdef NODE_CALL_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
        wd_cnt_d    = wd_cnt_q;
        wd_inc      = (wd_cnt_q == 16'hFFFF) ? wd_cnt_q : wd_cnt_q + 16'd1;
`endif
        case (state_q)
            IDLE: begin
                // Only launch into a child that reports idle.
                if (REQ_VALID && RD) begin
                    arg0_d  = REQ_A;
                    arg1_d  = REQ_B;
                    st_d    = 1'b1;
                    state_d = LAUNCH;
`ifdef NODE_CALL_TIMEOUT_EN
                    wd_cnt_d = '0;
`endif
                end
            end
            LAUNCH: begin
                // Child dropping RD is the start acknowledge.
                if (!RD) begin
                    st_d    = 1'b0;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (RD) begin
                    rsp_data_d  = RES;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
`ifdef NODE_CALL_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                end
            end
            RESP: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef NODE_CALL_TIMEOUT_EN
        // A normal completion on the same edge wins over the watchdog.
        if (state_q == LAUNCH || state_q == WAIT_DONE) begin
            wd_cnt_d = wd_inc;
            if (state_d != RESP && wd_inc >= WD_LIMIT) begin
                st_d        = 1'b0;
                rsp_data_d  = '0;
                rsp_err_d   = 1'b1;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
        end
`endif
    end

    // State and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            st_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            arg0_q      <= '0;
            arg1_q      <= '0;
`ifdef NODE_CALL_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
            wd_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            arg0_q      <= arg0_d;
            arg1_q      <= arg1_d;
`ifdef NODE_CALL_TIMEOUT_EN
            rsp_err_q   <= rsp_err_d;
            wd_cnt_q    <= wd_cnt_d;
`endif
        end
    end

    assign REQ_READY = (state_q == IDLE) && RD;
    assign BUSY      = (state_q != IDLE);
    assign ST        = st_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_DATA  = rsp_data_q;
    assign ARG0      = arg0_q;
    assign ARG1      = arg1_q;
`ifdef NODE_CALL_TIMEOUT_EN
    assign RSP_ERR   = rsp_err_q;
`else
    assign RSP_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_node_call_master.sv
// Randomized bench for node_call_master with a behavioural child node and a
// job-queue reference model. Build with NODE_CALL_TIMEOUT_EN to add the
// watchdog scenario.
module tb_node_call_master;

    localparam int W  = 16;
    localparam int TO = 20;

    logic         CLK, RST;
    logic         REQ_VALID, REQ_READY;
    logic [W-1:0] REQ_A, REQ_B;
    logic         RSP_VALID, RSP_READY;
    logic [W-1:0] RSP_DATA;
    logic         RSP_ERR, ST, RD, BUSY;
    logic [W-1:0] RES, ARG0, ARG1;

    node_call_master #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_A(REQ_A), .REQ_B(REQ_B),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
        .ST(ST), .RD(RD), .RES(RES),
        .ARG0(ARG0), .ARG1(ARG1), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           ack;
        int           lat;
        bit           hang;
    } job_t;

    job_t q[$];
    int   n_chk = 0, n_err = 0;
    int   n_acc = 0, n_rsp = 0;
    int   cur_ack = 1, cur_lat = 1;
    bit   hang = 0;
    int   rr_mode = 2;  // 0 random, 1 hold low, 2 hold high
    int   lat_ctr = 0, st_len = 0, st_rises = 0;
    bit   st_prev = 0, rsp_seen = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Child node: drops RD cur_ack cycles after ST rises, stays busy
    // cur_lat cycles, then returns ARG0+ARG1 with RD=1 (never, while hang).
    initial begin
        int ph, cnt, c_ack, c_lat;
        ph = 0; cnt = 0; c_ack = 1; c_lat = 1;
        RD = 1'b1; RES = '0;
        forever begin
            @(posedge CLK); #1;
            if (!RST) begin
                ph = 0; RD = 1'b1;
            end else begin
                if (ph == 0 && ST) begin
                    c_ack = cur_ack; c_lat = cur_lat; cnt = c_ack - 1; ph = 1;
                end
                if (ph == 1) begin
                    if (cnt == 0) begin
                        RD = 1'b0; RES = W'($urandom); cnt = c_lat - 1; ph = 2;
                    end else cnt--;
                end else if (ph == 2) begin
                    if (cnt == 0 && !hang) begin
                        RD = 1'b1; RES = ARG0 + ARG1; ph = 0;
                    end else if (cnt > 0) cnt--;
                end
            end
        end
    end

    // Response consumer.
    initial begin
        RSP_READY = 1'b0;
        forever begin
            @(posedge CLK); #2;
            case (rr_mode)
                0:       RSP_READY = 1'($urandom_range(0, 1));
                1:       RSP_READY = 1'b0;
                default: RSP_READY = 1'b1;
            endcase
        end
    end

    // Reference model: one job in flight, checked on every falling edge.
    always @(negedge CLK) begin
        job_t         j;
        logic [W-1:0] sum;
        int           exp_lat;
        if (!RST) begin
            q.delete(); st_prev = 0; st_len = 0; st_rises = 0; rsp_seen = 0;
        end else begin
            lat_ctr++;
            chk("req_ready", {31'd0, REQ_READY}, (q.size() == 0 && RD) ? 32'd1 : 32'd0);
            chk("busy", {31'd0, BUSY}, (q.size() != 0) ? 32'd1 : 32'd0);
            if (q.size() > 0) begin
                chk("arg0", {16'd0, ARG0}, {16'd0, q[0].a});
                chk("arg1", {16'd0, ARG1}, {16'd0, q[0].b});
            end
            if (ST && !st_prev) st_rises++;
            if (ST) st_len++;
            else if (st_prev) begin
                if (q.size() > 0) chk("st_high", st_len, q[0].ack);
                st_len = 0;
            end
            st_prev = ST;
            if (RSP_VALID && !rsp_seen) begin
                rsp_seen = 1;
                if (q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
                else begin
                    exp_lat = q[0].hang ? TO + 1 : q[0].ack + q[0].lat + 1;
                    chk("rsp_latency", lat_ctr, exp_lat);
                end
            end
            if (RSP_VALID && RSP_READY && q.size() > 0) begin
                j = q.pop_front();
                sum = j.a + j.b;
                chk("rsp_data", {16'd0, RSP_DATA}, j.hang ? 32'd0 : {16'd0, sum});
                chk("rsp_err", {31'd0, RSP_ERR}, {31'd0, j.hang});
                chk("st_rises", st_rises, 1);
                st_rises = 0; rsp_seen = 0; n_rsp++;
            end
            if (REQ_VALID && REQ_READY) begin
                j.a = REQ_A; j.b = REQ_B; j.ack = cur_ack; j.lat = cur_lat; j.hang = hang;
                q.push_back(j);
                lat_ctr = 0; n_acc++;
            end
        end
    end

    task automatic align();
        @(posedge CLK); #2;
    endtask

    task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int ack, input int lat, input bit keep);
        int t, n0;
        REQ_A = a; REQ_B = b; cur_ack = ack; cur_lat = lat; REQ_VALID = 1'b1;
        n0 = n_acc; t = 0;
        do begin align(); t++; end while (n_acc == n0 && t < 500);
        chk("accept_timeout", (n_acc != n0) ? 32'd1 : 32'd0, 32'd1);
        if (!keep) REQ_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((q.size() != 0 || BUSY) && t < 300) begin @(negedge CLK); t++; end
        chk("idle_timeout", (t < 300) ? 32'd1 : 32'd0, 32'd1);
        align();
    endtask

    task automatic wait_rsp_valid();
        int t;
        t = 0;
        while (!RSP_VALID && t < 300) begin @(negedge CLK); t++; end
        chk("rsp_timeout", (t < 300) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        RST = 1'b0; REQ_VALID = 1'b0; REQ_A = '0; REQ_B = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_st", {31'd0, ST}, 0);
        chk("rst_rsp_valid", {31'd0, RSP_VALID}, 0);
        chk("rst_rsp_data", {16'd0, RSP_DATA}, 0);
        chk("rst_rsp_err", {31'd0, RSP_ERR}, 0);
        chk("rst_busy", {31'd0, BUSY}, 0);
        chk("rst_arg0", {16'd0, ARG0}, 0);
        align();
        RST = 1'b1;
        align();

        // Single job, child busy 5 cycles.
        run_job(16'd3, 16'd4, 1, 5, 0);
        wait_idle();

        // Response backpressure for 10 cycles.
        rr_mode = 1;
        run_job(16'd3, 16'd4, 2, 3, 0);
        wait_rsp_valid();
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("bp_rsp_valid", {31'd0, RSP_VALID}, 1);
            chk("bp_rsp_data", {16'd0, RSP_DATA}, 7);
            chk("bp_req_ready", {31'd0, REQ_READY}, 0);
            chk("bp_st", {31'd0, ST}, 0);
        end
        align();
        rr_mode = 2;
        wait_idle();

        // Back-to-back with REQ_VALID held, wraparound sum.
        run_job(16'd1, 16'd1, 1, 2, 1);
        run_job(16'hFFFF, 16'd1, 1, 2, 0);
        wait_idle();

        // Slow start acknowledge.
        run_job(16'd9, 16'd8, 4, 3, 0);
        wait_idle();

        // Randomized jobs, random response readiness.
        rr_mode = 0;
        for (int i = 0; i < 40; i++) begin
            run_job(W'($urandom), W'($urandom), $urandom_range(1, 4), $urandom_range(1, 6),
                    1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                REQ_VALID = 1'b0;
                wait_idle();
            end
        end
        REQ_VALID = 1'b0;
        wait_idle();
        rr_mode = 2;

`ifdef NODE_CALL_TIMEOUT_EN
        // Child acknowledges but never completes.
        begin
            int t, n0;
            hang = 1;
            n0 = n_rsp;
            run_job(16'd5, 16'd6, 2, 1, 0);
            t = 0;
            while (n_rsp == n0 && t < TO + 50) begin @(negedge CLK); t++; end
            chk("wd_timeout", (n_rsp != n0) ? 32'd1 : 32'd0, 32'd1);
            for (int i = 0; i < 5; i++) begin
                @(negedge CLK);
                chk("wd_req_ready", {31'd0, REQ_READY}, 0);
            end
            align();
            hang = 0;
            repeat (3) align();
            wait_idle();
            run_job(16'd2, 16'd2, 1, 1, 0);
            wait_idle();
        end
`endif

        // Asynchronous reset while ST is asserted.
        run_job(16'd9, 16'd9, 4, 2, 0);
        chk("pre_rst_st", {31'd0, ST}, 1);
        #3;
        RST = 1'b0;
        #1;
        chk("arst_st", {31'd0, ST}, 0);
        chk("arst_rsp_valid", {31'd0, RSP_VALID}, 0);
        chk("arst_rsp_data", {16'd0, RSP_DATA}, 0);
        chk("arst_rsp_err", {31'd0, RSP_ERR}, 0);
        chk("arst_arg0", {16'd0, ARG0}, 0);
        chk("arst_arg1", {16'd0, ARG1}, 0);
        chk("arst_busy", {31'd0, BUSY}, 0);
        repeat (2) align();
        RST = 1'b1;
        @(negedge CLK);
        chk("post_rst_ready", {31'd0, REQ_READY}, 1);
        align();
        run_job(16'd10, 16'd20, 1, 1, 0);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
